stream_zero_compressor: RTL and testbench

- Parametrised successor to the packet compressor: AXI-Stream in, AXI-Stream out.
- The first HDR_BEATS beats of every packet pass through unchanged.
- Each payload beat is recoded as a lane-mask word followed only by its non-zero words. These are packed contiguously across output beats, and m_tkeep marks the valid bytes of the final beat.
- Adds full output backpressure, partial final beats, and a per-packet bypass mode.

---
 rtl/stream_zero_compressor.sv | 224 ++++++++++++++++++++++
 tb/tb_stream_zero_compressor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_zero_compressor.sv
// AXI-Stream zero compressor: header beats pass through, payload beats become a lane
// mask plus their non-zero words, packed contiguously into output beats.
module stream_zero_compressor #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 8,
    parameter int HDR_BEATS  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wrt_en,
    input  logic [DATA_WIDTH*NUM_DATA-1:0]   s_data,
    input  logic                             s_tvalid,
    input  logic                             s_tlast,
    output logic                             s_tready,
    output logic [DATA_WIDTH*NUM_DATA-1:0]   m_data,
    output logic                             m_tvalid,
    output logic                             m_tlast,
    input  logic                             m_tready,
    output logic [DATA_WIDTH*NUM_DATA/8-1:0] m_tkeep
);

    localparam int DEPTH = 2 * NUM_DATA;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(NUM_DATA + 2);
    localparam int HC_W  = (HDR_BEATS > 0) ? $clog2(HDR_BEATS + 1) : 1;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int KW    = DATA_WIDTH * NUM_DATA / 8;

    localparam logic [OCC_W-1:0] OCC_N     = OCC_W'(NUM_DATA);
    localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(DEPTH);
    localparam logic [HC_W-1:0]  HC_LAST   = HC_W'(HDR_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_BYP,
        ST_FLUSH
    } state_t;

    state_t                  st_q, st_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [HC_W-1:0]         hcnt_q, hcnt_d;
    logic                    byp_q, byp_d;
    logic [DATA_WIDTH-1:0]   acc_q [DEPTH];
    logic [DATA_WIDTH-1:0]   acc_d [DEPTH];
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [KW-1:0]           m_tkeep_q, m_tkeep_d;

    logic [DATA_WIDTH-1:0]   lane [NUM_DATA];
    logic [NUM_DATA-1:0]     nz;
    logic [CNT_W-1:0]        slot [NUM_DATA];
    logic [CNT_W-1:0]        pay_cnt;
    logic [DATA_WIDTH-1:0]   app [NUM_DATA+1];

    logic [DATA_WIDTH-1:0]   acc_pop [DEPTH];
    logic [OCC_W-1:0]        occ_pop;
    logic [DATA_WIDTH-1:0]   rec [NUM_DATA+1];
    logic [CNT_W-1:0]        rec_cnt;
    state_t                  cur;
    logic                    byp_eff;
    logic                    verbatim;
    logic                    accept;
    logic                    pop;

    // slot[i] is where lane i lands in the payload record (slot 0 is the mask word).
    generate
        for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_lane
            assign lane[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign nz[gi]   = |lane[gi];
            if (gi == 0) begin : g_first
                assign slot[gi] = CNT_W'(1);
            end else begin : g_rest
                assign slot[gi] = slot[gi-1] + CNT_W'(nz[gi-1]);
            end
            assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = acc_q[gi];
            assign m_tkeep_d[gi*BYTES +: BYTES] = {BYTES{occ_d > OCC_W'(gi)}};
        end
    endgenerate

    assign pay_cnt = slot[NUM_DATA-1] + CNT_W'(nz[NUM_DATA-1]);

    always_comb begin
        for (int k = 0; k <= NUM_DATA; k++) begin
            app[k] = '0;
        end
        app[0][NUM_DATA-1:0] = nz;
        for (int k = 1; k <= NUM_DATA; k++) begin
            for (int i = 0; i < NUM_DATA; i++) begin
                if (nz[i] && slot[i] == CNT_W'(k)) begin
                    app[k] = lane[i];
                end
            end
        end
    end

    // Holding off input at a full accumulator keeps a pop-then-push within 2*NUM_DATA words.
    assign s_tready = (st_q != ST_FLUSH) &&
                      ((occ_q < OCC_N) || (m_tready && occ_q != OCC_DEPTH));
    assign accept   = s_tvalid && s_tready;
    assign pop      = m_tvalid_q && m_tready;

    always_comb begin
        st_d     = st_q;
        hcnt_d   = hcnt_q;
        byp_d    = byp_q;
        acc_pop  = acc_q;
        occ_pop  = occ_q;
        cur      = st_q;
        byp_eff  = byp_q;
        verbatim = 1'b0;
        rec_cnt  = '0;
        for (int k = 0; k <= NUM_DATA; k++) begin
            rec[k] = '0;
        end

        // Pop first; vacated words are zeroed so unused output lanes read as zero.
        if (pop) begin
            if (occ_q >= OCC_N) begin
                for (int j = 0; j < NUM_DATA; j++) begin
                    acc_pop[j] = acc_q[j + NUM_DATA];
                end
                for (int j = NUM_DATA; j < DEPTH; j++) begin
                    acc_pop[j] = '0;
                end
                occ_pop = occ_q - OCC_N;
            end else begin
                for (int j = 0; j < DEPTH; j++) begin
                    acc_pop[j] = '0;
                end
                occ_pop = '0;
            end
            if (st_q == ST_FLUSH && occ_q <= OCC_N) begin
                st_d = ST_IDLE;
            end
        end

        acc_d = acc_pop;
        occ_d = occ_pop;

        if (accept) begin
            if (st_q == ST_IDLE) begin
                byp_eff = !wrt_en;
                byp_d   = !wrt_en;
                if (!wrt_en) begin
                    cur = ST_BYP;
                end else if (HDR_BEATS > 0) begin
                    cur = ST_HDR;
                end else begin
                    cur = ST_PAY;
                end
            end
            verbatim = byp_eff || (cur == ST_HDR);

            if (verbatim) begin
                for (int k = 0; k < NUM_DATA; k++) begin
                    rec[k] = lane[k];
                end
                rec_cnt = CNT_W'(NUM_DATA);
            end else begin
                rec     = app;
                rec_cnt = pay_cnt;
            end

            // Append the record right after the words that survive the pop.
            for (int j = 0; j < DEPTH; j++) begin
                for (int k = 0; k <= NUM_DATA; k++) begin
                    if (k < int'(rec_cnt) && int'(occ_pop) + k == j) begin
                        acc_d[j] = rec[k];
                    end
                end
            end
            occ_d = occ_pop + OCC_W'(rec_cnt);

            if (s_tlast) begin
                st_d   = ST_FLUSH;
                hcnt_d = '0;
            end else if (cur == ST_HDR) begin
                if (hcnt_q == HC_LAST) begin
                    st_d   = ST_PAY;
                    hcnt_d = '0;
                end else begin
                    st_d   = ST_HDR;
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end else begin
                st_d = cur;
            end
        end

        m_tvalid_d = (occ_d >= OCC_N) || (st_d == ST_FLUSH && occ_d != '0);
        m_tlast_d  = (st_d == ST_FLUSH) && (occ_d <= OCC_N);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q       <= ST_IDLE;
            occ_q      <= '0;
            hcnt_q     <= '0;
            byp_q      <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tkeep_q  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            st_q       <= st_d;
            occ_q      <= occ_d;
            hcnt_q     <= hcnt_d;
            byp_q      <= byp_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tkeep_q  <= m_tkeep_d;
            acc_q      <= acc_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tkeep  = m_tkeep_q;

endmodule

// File: tb/tb_stream_zero_compressor.sv
// Directed bench for stream_zero_compressor: table-driven packets plus backpressure
// and mid-packet reset sequences, compared against hand-computed output beats.
module tb_stream_zero_compressor;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int HB = 2;
    localparam int BW = W * N;
    localparam int KW = BW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wrt_en;
    logic [BW-1:0] s_data;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [BW-1:0] m_data;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [KW-1:0] m_tkeep;

    always #5 clk = ~clk;

    stream_zero_compressor #(
        .DATA_WIDTH(W),
        .NUM_DATA  (N),
        .HDR_BEATS (HB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wrt_en  (wrt_en),
        .s_data  (s_data),
        .s_tvalid(s_tvalid),
        .s_tlast (s_tlast),
        .s_tready(s_tready),
        .m_data  (m_data),
        .m_tvalid(m_tvalid),
        .m_tlast (m_tlast),
        .m_tready(m_tready),
        .m_tkeep (m_tkeep)
    );

    typedef struct {
        int            sc;
        logic [BW-1:0] data;
        logic          last;
        logic          wen;
    } in_t;

    typedef struct {
        int            sc;
        logic [BW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } out_t;

    in_t  in_tab[$];
    out_t out_tab[$];
    out_t got[$];
    int   checks = 0;
    int   errors = 0;
    int   in_cnt = 0;

    localparam logic [31:0] XD = 32'hBA98FEDC;
    localparam logic [31:0] XB = 32'hFEDCBA98;
    localparam logic [KW-1:0] KALL = '1;

    function automatic logic [BW-1:0] lanes8(input logic [31:0] l0, l1, l2, l3,
                                             input logic [31:0] l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [BW-1:0] rep(input logic [31:0] w);
        return {N{w}};
    endfunction

    function automatic logic [BW-1:0] seq(input logic [31:0] base);
        logic [BW-1:0] b;
        for (int i = 0; i < N; i++) b[i*W +: W] = base + 32'(i);
        return b;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Output monitor: records every handshaken beat, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            out_t o;
            o.sc   = 0;
            o.data = m_data;
            o.keep = m_tkeep;
            o.last = m_tlast;
            got.push_back(o);
        end
    end

    task automatic send(input in_t v);
        int budget;
        @(negedge clk);
        s_data   = v.data;
        s_tlast  = v.last;
        wrt_en   = v.wen;
        s_tvalid = 1'b1;
        budget   = 0;
        forever begin
            #1;
            if (s_tready) begin
                @(posedge clk);
                break;
            end
            budget++;
            if (budget > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_tready=%b required 1 within 100 cycles", s_tready);
                break;
            end
            @(negedge clk);
        end
        in_cnt++;
    endtask

    task automatic drive_scen(input int s);
        foreach (in_tab[i]) begin
            if (in_tab[i].sc == s) send(in_tab[i]);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_scen(input int s);
        int n = 0;
        int k = 0;
        int t = 0;
        foreach (out_tab[i]) if (out_tab[i].sc == s) n++;
        while (got.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk($sformatf("sc%0d_beat_count", s), BW'(got.size()), BW'(n));
        foreach (out_tab[i]) begin
            if (out_tab[i].sc == s && k < got.size()) begin
                $display("beat sc=%0d #%0d data=%h keep=%h last=%b",
                         s, k, got[k].data, got[k].keep, got[k].last);
                chk($sformatf("sc%0d_b%0d_data", s, k), got[k].data, out_tab[i].data);
                chk($sformatf("sc%0d_b%0d_keep", s, k), BW'(got[k].keep), BW'(out_tab[i].keep));
                chk($sformatf("sc%0d_b%0d_last", s, k), BW'(got[k].last), BW'(out_tab[i].last));
                k++;
            end
        end
        got.delete();
    endtask

    task automatic stall_sequence();
        int t = 0;
        forever begin
            @(negedge clk);
            if (in_cnt >= 2 || t > 200) break;
            t++;
        end
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("bp_s_tready_c%0d", c), BW'(s_tready), BW'(0));
            chk($sformatf("bp_m_tvalid_c%0d", c), BW'(m_tvalid), BW'(1));
            chk($sformatf("bp_hold_data_c%0d", c), m_data, seq(32'hB0000000));
            @(negedge clk);
        end
        m_tready = 1'b1;
    endtask

    initial begin
        // sc0: header passthrough with an all-zero payload beat
        in_tab.push_back('{0, seq(32'hA0000000), 1'b0, 1'b1});
        in_tab.push_back('{0, seq(32'hB0000000), 1'b0, 1'b1});
        in_tab.push_back('{0, rep(32'h0), 1'b1, 1'b1});
        out_tab.push_back('{0, seq(32'hA0000000), KALL, 1'b0});
        out_tab.push_back('{0, seq(32'hB0000000), KALL, 1'b0});
        out_tab.push_back('{0, rep(32'h0), KW'(32'h0000000F), 1'b1});
        // sc1: dense payload, 18 words packed across three beats
        in_tab.push_back('{1, seq(32'hA0000000), 1'b0, 1'b1});
        in_tab.push_back('{1, seq(32'hB0000000), 1'b0, 1'b1});
        in_tab.push_back('{1, rep(XD), 1'b0, 1'b1});
        in_tab.push_back('{1, rep(XD), 1'b1, 1'b1});
        out_tab.push_back('{1, seq(32'hA0000000), KALL, 1'b0});
        out_tab.push_back('{1, seq(32'hB0000000), KALL, 1'b0});
        out_tab.push_back('{1, lanes8(32'hFF, XD, XD, XD, XD, XD, XD, XD), KALL, 1'b0});
        out_tab.push_back('{1, lanes8(XD, 32'hFF, XD, XD, XD, XD, XD, XD), KALL, 1'b0});
        out_tab.push_back('{1, lanes8(XD, XD, 0, 0, 0, 0, 0, 0), KW'(32'h000000FF), 1'b1});
        // sc2: sparse payload
        in_tab.push_back('{2, seq(32'hA0000000), 1'b0, 1'b1});
        in_tab.push_back('{2, seq(32'hB0000000), 1'b0, 1'b1});
        in_tab.push_back('{2, lanes8(0, 32'h11, 0, 0, 0, 32'h55, 0, 0), 1'b1, 1'b1});
        out_tab.push_back('{2, seq(32'hA0000000), KALL, 1'b0});
        out_tab.push_back('{2, seq(32'hB0000000), KALL, 1'b0});
        out_tab.push_back('{2, lanes8(32'h22, 32'h11, 32'h55, 0, 0, 0, 0, 0), KW'(32'h00000FFF), 1'b1});
        // sc3: bypass, wrt_en toggled after the first beat
        in_tab.push_back('{3, seq(32'h10000000), 1'b0, 1'b0});
        in_tab.push_back('{3, lanes8(XB, XB, XB, 0, XB, XB, XB, XB), 1'b0, 1'b1});
        in_tab.push_back('{3, rep(XB), 1'b1, 1'b1});
        out_tab.push_back('{3, seq(32'h10000000), KALL, 1'b0});
        out_tab.push_back('{3, lanes8(XB, XB, XB, 0, XB, XB, XB, XB), KALL, 1'b0});
        out_tab.push_back('{3, rep(XB), KALL, 1'b1});
        // sc4: single tlast beat in compress mode (counts as a header beat)
        in_tab.push_back('{4, seq(32'hC0000000), 1'b1, 1'b1});
        out_tab.push_back('{4, seq(32'hC0000000), KALL, 1'b1});
        // sc5: single tlast beat in bypass mode, zero lanes kept verbatim
        in_tab.push_back('{5, lanes8(0, 0, 0, 7, 0, 0, 0, 0), 1'b1, 1'b0});
        out_tab.push_back('{5, lanes8(0, 0, 0, 7, 0, 0, 0, 0), KALL, 1'b1});
        // sc6: three short payload records packed into one partial beat
        in_tab.push_back('{6, seq(32'hA0000000), 1'b0, 1'b1});
        in_tab.push_back('{6, seq(32'hB0000000), 1'b0, 1'b1});
        in_tab.push_back('{6, lanes8(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1});
        in_tab.push_back('{6, rep(32'h0), 1'b0, 1'b1});
        in_tab.push_back('{6, lanes8(0, 0, 0, 0, 0, 0, 0, 9), 1'b1, 1'b1});
        out_tab.push_back('{6, seq(32'hA0000000), KALL, 1'b0});
        out_tab.push_back('{6, seq(32'hB0000000), KALL, 1'b0});
        out_tab.push_back('{6, lanes8(1, 1, 0, 32'h80, 9, 0, 0, 0), KW'(32'h000FFFFF), 1'b1});

        reset    = 1'b1;
        wrt_en   = 1'b0;
        s_data   = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_m_tvalid", BW'(m_tvalid), BW'(0));
        chk("rst_m_tlast", BW'(m_tlast), BW'(0));
        chk("rst_m_tkeep", BW'(m_tkeep), BW'(0));
        chk("rst_m_data", m_data, '0);
        chk("rst_s_tready", BW'(s_tready), BW'(1));
        @(negedge clk);
        reset = 1'b0;

        for (int s = 0; s <= 6; s++) begin
            drive_scen(s);
            check_scen(s);
        end

        // Dense packet again with a 5-cycle downstream stall at the first payload beat.
        in_cnt = 0;
        fork
            drive_scen(1);
            stall_sequence();
        join
        check_scen(1);

        // Reset right after header beat 1 is accepted, then a clean sparse packet.
        send(in_tab[0]);
        send(in_tab[1]);
        @(negedge clk);
        s_tvalid = 1'b0;
        reset    = 1'b1;
        #2;
        chk("midrst_m_tvalid", BW'(m_tvalid), BW'(0));
        chk("midrst_m_tlast", BW'(m_tlast), BW'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_s_tready", BW'(s_tready), BW'(1));
        got.delete();
        drive_scen(2);
        check_scen(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
